draw_obstacle_sprite: RTL and testbench
=======================================

Name: draw_obstacle_sprite

Overview:
- Reads the 48x64 obstacle image ROM and overlays the sprite onto the VGA timing/pixel stream at a frame-latched position.
- Generates the 12-bit ROM address {y[5:0], x[5:0]}.
- Absorbs the ROM's one-cycle registered read latency.
- Outputs delayed timing, muxed RGB and a per-pixel "obstacle drawn" flag used downstream for collision.
- Sits between the timing/background chain and the next draw stage.

Parameters:
- SPR_W, 48, sprite width in pixels (must be ≤ 64).
- SPR_H, 64, sprite height in pixels (must be ≤ 64).
- KEY_RGB, 12'h000, transparent colour key; sprite pixels equal to it are not drawn.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- hblnk_in  in  1  horizontal blank
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  background pixel
- xpos  in  11  requested sprite left edge (screen x)
- ypos  in  11  requested sprite top edge (screen y)
- rom_addr  out  12  ROM address {vrel[5:0], hrel[5:0]}
- rom_rgb  in  12  ROM data; valid one clk after rom_addr is registered
- hcount_out, vcount_out  out  11 each  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited pixel
- obst_px  out  1  1 when rgb_out carries an opaque sprite pixel

Behaviour:
- Reset (rst = 0, asynchronous): every output register, pipeline register and position latch clears to 0; rom_addr = 0; rgb_out = 0; obst_px = 0. Reset mid-frame aborts in-flight pixels. Outputs resume exactly 3 clks after release with valid data.
- Position latch:
  - x_lat/y_lat load xpos/ypos only on the rising edge of vblnk_in (vblnk_in = 1 and registered previous value = 0).
  - Position is therefore constant across a visible frame. Mid-frame xpos/ypos changes take effect next frame.
- Stage 1 (clk edge N, inputs sampled):
  - hrel = hcount_in − x_lat, vrel = vcount_in − y_lat, computed at 12 bits.
  - in_rect = (hcount_in ≥ x_lat) && (hcount_in < x_lat+SPR_W) && (vcount_in ≥ y_lat) && (vcount_in < y_lat+SPR_H). Sums are 12-bit; no wrap.
  - Blanking is not part of in_rect; stage 3 masks it.
  - rom_addr <= in_rect ? {vrel[5:0], hrel[5:0]} : 12'h000.
  - All timing, rgb_in and in_rect are registered (d1).
- Stage 2 (edge N+1): ROM registers rom_rgb; all d1 values move to d2.
- Stage 3 (edge N+2):
  - Timing and counters output = d2.
  - If hblnk_d2 or vblnk_d2: rgb_out = 12'h000, obst_px = 0.
  - Else if in_rect_d2 && rom_rgb ≠ KEY_RGB: rgb_out = rom_rgb, obst_px = 1.
  - Else: rgb_out = rgb_d2, obst_px = 0.
- Latency: exactly 3 clks from any input sample to the corresponding output, for all outputs. Every stage advances every clk; no stall.
- Clipping: a sprite extending past the visible area is drawn only where the counters reach; no wrap to the opposite edge. xpos near 2047 yields no drawing.
- Pixel columns 48–63 of the ROM are never addressed.

Test Plan:
- Reset: hold rst = 0 for 5 clks with random inputs → all outputs 0; release → first valid output 3 clks after release.
- Latency/alignment: x_lat = 100, y_lat = 50, ROM model returns address as data.
  - Input (100,50) → rom_addr = 12'h000; 3 clks later rgb_out = 12'h000 (key), so background shows.
  - Input (147,113) → rom_addr = {6'd63, 6'd47} = 12'hFEF; rgb_out = 12'hFEF, obst_px = 1.
- Edges: (99,50), (148,50), (100,49), (100,114) → in_rect = 0, rgb_out = rgb_in delayed 3, obst_px = 0, rom_addr = 0.
- Frame latch: change xpos 100→300 mid-frame → drawing stays at x = 100 until the vblnk_in rising edge; next frame sprite starts at hcount 300.
- Blanking: in_rect = 1 with hblnk_in = 1 → rgb_out = 12'h000, obst_px = 0.
- Clipping: xpos = 780 with 800-wide visible area → columns 0–19 drawn at hcount 780–799; no pixels appear at hcount 0–27 of the next line.

Source files
------------

// File: rtl/draw_obstacle_sprite.sv
// Obstacle sprite overlay stage.
// Three-stage pipeline: address generation, ROM read, composite.
// The sprite position is latched once per frame, on the rising edge of
// vblnk_in, so the sprite cannot tear mid-frame.
module draw_obstacle_sprite #(
  parameter int          SPR_W   = 48,
  parameter int          SPR_H   = 64,
  parameter logic [11:0] KEY_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        obst_px
);

  // Timing and pixel data carried down the pipeline.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        in_rect;
  } pix_t;

  // Registered outputs of the composite stage.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        obst;
  } out_t;

  logic        vblnk_prev_q, vblnk_prev_d;
  logic [10:0] x_lat_q, x_lat_d;
  logic [10:0] y_lat_q, y_lat_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  pix_t        s1_q, s1_d;
  pix_t        s2_q, s2_d;
  out_t        out_q, out_d;

  logic [11:0] x_end, y_end;
  logic [5:0]  hrel, vrel;
  logic        in_rect;

  // Frame position latch: reload only on vblnk_in rising edge.
  always_comb begin
    vblnk_prev_d = vblnk_in;
    x_lat_d      = x_lat_q;
    y_lat_d      = y_lat_q;
    if (vblnk_in && !vblnk_prev_q) begin
      x_lat_d = xpos;
      y_lat_d = ypos;
    end
  end

  // Stage 1: rectangle test and ROM address.
  // Only the low 6 bits of the relative offsets are addressed, and the low
  // bits of a difference depend only on the low bits of its operands.
  // Bounds are 12-bit sums so a sprite near 2047 never wraps to column 0.
  always_comb begin
    x_end   = {1'b0, x_lat_q} + 12'(SPR_W);
    y_end   = {1'b0, y_lat_q} + 12'(SPR_H);
    hrel    = hcount_in[5:0] - x_lat_q[5:0];
    vrel    = vcount_in[5:0] - y_lat_q[5:0];
    in_rect = (hcount_in >= x_lat_q) && ({1'b0, hcount_in} < x_end) &&
              (vcount_in >= y_lat_q) && ({1'b0, vcount_in} < y_end);
    rom_addr_d = in_rect ? {vrel, hrel} : 12'h000;
    s1_d = '{hcount:  hcount_in, vcount: vcount_in,
             hsync:   hsync_in,  vsync:  vsync_in,
             hblnk:   hblnk_in,  vblnk:  vblnk_in,
             rgb:     rgb_in,    in_rect: in_rect};
  end

  // Stage 2: delay alongside the ROM's registered read.
  always_comb begin
    s2_d = s1_q;
  end

  // Stage 3: blanking mask, then colour-keyed overlay over the background.
  always_comb begin
    out_d = '{hcount: s2_q.hcount, vcount: s2_q.vcount,
              hsync:  s2_q.hsync,  vsync:  s2_q.vsync,
              hblnk:  s2_q.hblnk,  vblnk:  s2_q.vblnk,
              rgb:    s2_q.rgb,    obst:   1'b0};
    if (s2_q.hblnk || s2_q.vblnk) begin
      out_d.rgb = 12'h000;
    end else if (s2_q.in_rect && (rom_rgb != KEY_RGB)) begin
      out_d.rgb  = rom_rgb;
      out_d.obst = 1'b1;
    end
  end

  // All state; asynchronous reset aborts any in-flight pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_prev_q <= 1'b0;
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      rom_addr_q   <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_q        <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      x_lat_q      <= x_lat_d;
      y_lat_q      <= y_lat_d;
      rom_addr_q   <= rom_addr_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      out_q        <= out_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign hblnk_out  = out_q.hblnk;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;
  assign obst_px    = out_q.obst;

endmodule

// File: tb/tb_draw_obstacle_sprite.sv
// Bench for draw_obstacle_sprite: directed corner pixels plus randomized
// raster traffic, checked against a screen-coordinate reference model.
module tb_draw_obstacle_sprite;
  localparam int SPR_W = 48;
  localparam int SPR_H = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0, xpos = '0, ypos = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, obst_px;
  logic [11:0] rgb_out;

  draw_obstacle_sprite dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .obst_px(obst_px)
  );

  always #5 clk = ~clk;

  // Image content: address as data, with every xxx5 address transparent.
  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return (a[3:0] == 4'h5) ? 12'h000 : a;
  endfunction

  // Synchronous ROM, one clock read latency.
  always @(posedge clk) rom_rgb <= rom_f(rom_addr);

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state: latched sprite origin and 3-deep output history.
  int          mx = 0, my = 0;
  bit          mprev = 0;
  logic [38:0] pipe [3] = '{default: '0};
  logic [11:0] exp_addr = '0;

  task automatic model_clear();
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    exp_addr = '0; mx = 0; my = 0; mprev = 0;
  endtask

  // One clock: update the model with the sampled inputs, then compare.
  task automatic tick(input bit do_chk);
    int h, v;
    bit in;
    logic [11:0] px, a;
    logic ob;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      h  = int'(hcount_in);
      v  = int'(vcount_in);
      in = (h >= mx) && (h < mx + SPR_W) && (v >= my) && (v < my + SPR_H);
      a  = in ? 12'(((v - my) % 64) * 64 + ((h - mx) % 64)) : 12'h000;
      ob = 1'b0;
      if (hblnk_in || vblnk_in)          px = 12'h000;
      else if (in && rom_f(a) != 12'h000) begin px = rom_f(a); ob = 1'b1; end
      else                               px = rgb_in;
      pipe[2]  = pipe[1];
      pipe[1]  = pipe[0];
      pipe[0]  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, px, ob};
      exp_addr = a;
      if (vblnk_in && !mprev) begin mx = int'(xpos); my = int'(ypos); end
      mprev = vblnk_in;
    end
    #1;
    if (do_chk) begin
      chk("pix", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                  vblnk_out, rgb_out, obst_px}, pipe[2]);
      chk("addr", rom_addr, exp_addr);
    end
  endtask

  task automatic drive(input int h, input int v, input bit hb, input bit vb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    rgb_in    = 12'($urandom);
  endtask

  // Load a new sprite origin through a vblnk_in pulse.
  task automatic latch_pos(input int x, input int y);
    xpos = 11'(x); ypos = 11'(y);
    drive(0, 600, 1, 0); tick(1);
    drive(0, 601, 1, 1); tick(1);
    drive(0, 602, 1, 1); tick(1);
    drive(0, 0, 1, 0);   tick(1);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin drive(0, 700, 1, 1); tick(1); end
  endtask

  int dh[7] = '{100, 147, 99, 148, 100, 100, 120};
  int dv[7] = '{50, 113, 50, 50, 49, 114, 60};

  initial begin
    // Reset held with random inputs: everything reads zero.
    for (int i = 0; i < 5; i++) begin
      drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
            1'($urandom), 1'($urandom));
      xpos = 11'($urandom); ypos = 11'($urandom);
      tick(1);
    end
    #3 rst = 1'b1;

    // Directed corners and the blanking mask around origin (100,50).
    latch_pos(100, 50);
    for (int i = 0; i < 7; i++) begin
      drive(dh[i], dv[i], i == 6, 0);
      tick(1);
    end
    flush();

    // Mid-frame position change waits for the next vblnk_in rise.
    xpos = 11'd300;
    drive(110, 60, 0, 0); tick(1);
    drive(310, 60, 0, 0); tick(1);
    flush();
    latch_pos(300, 50);
    drive(310, 60, 0, 0); tick(1);
    drive(110, 60, 0, 0); tick(1);
    flush();

    // Right-edge clipping, then start of the following line.
    latch_pos(780, 10);
    for (int h = 760; h < 800; h++) begin drive(h, 20, 0, 0); tick(1); end
    for (int h = 800; h < 810; h++) begin drive(h, 20, 1, 0); tick(1); end
    for (int h = 0; h < 40; h++)    begin drive(h, 21, 0, 0); tick(1); end
    flush();

    // Origin at the top of the counter range.
    latch_pos(2040, 100);
    for (int h = 2030; h < 2048; h++) begin drive(h, 120, 0, 0); tick(1); end
    for (int h = 0; h < 10; h++)      begin drive(h, 120, 0, 0); tick(1); end
    flush();

    // Randomized raster traffic around the sprite with occasional frames.
    latch_pos(100, 50);
    for (int i = 0; i < 1500; i++) begin
      xpos = 11'($urandom_range(60, 180));
      ypos = 11'($urandom_range(30, 110));
      drive(int'($urandom_range(60, 200)), int'($urandom_range(30, 130)),
            ($urandom % 16) == 0, ($urandom % 48) == 0);
      tick(1);
    end

    // Asynchronous reset in the middle of traffic.
    #2 rst = 1'b0;
    model_clear();
    #1 chk("async_rst", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                         vblnk_out, rgb_out, obst_px, rom_addr}, 64'h0);
    for (int i = 0; i < 2; i++) begin
      drive(int'($urandom_range(0, 100)), int'($urandom_range(0, 100)), 0, 0);
      tick(1);
    end
    #3 rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive(int'($urandom_range(0, 120)), int'($urandom_range(0, 120)),
            ($urandom % 16) == 0, ($urandom % 64) == 0);
      xpos = 11'($urandom_range(0, 80));
      ypos = 11'($urandom_range(0, 80));
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
